// File: rtl/change_event_monitor_if.sv
// rtl/change_event_monitor_if.sv - event record stream between the monitor and its consumer
interface change_event_monitor_if #(
  parameter int WIDTH = 4,
  parameter int TS_W  = 16,
  parameter int CH_W  = 2
);
  logic             rec_valid;
  logic             rec_ready;
  logic [CH_W-1:0]  rec_ch;
  logic [WIDTH-1:0] rec_val;
  logic [TS_W-1:0]  rec_ts;

  modport master (output rec_valid, rec_ch, rec_val, rec_ts, input rec_ready);
  modport slave  (input rec_valid, rec_ch, rec_val, rec_ts, output rec_ready);
endinterface

// File: rtl/change_event_monitor.sv
// rtl/change_event_monitor.sv - multi-channel change/increase/decrease detector with time-stamped event FIFO
// Optional per-channel saturating event counters: define CHANGE_EVENT_MONITOR_COUNT_EN.
module change_event_monitor #(
  parameter int NCH          = 4,
  parameter int WIDTH        = 4,
  parameter int DEPTH        = 8,
  parameter int TS_W         = 16,
  parameter int MODE         = 0,
  parameter int FIRST_CHANGE = 1,
  parameter int CNT_W        = 8,
  localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int PTR_W       = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 clear,
  output logic [NCH-1:0]       evt_pulse,
  output logic [PTR_W:0]       fifo_count,
  output logic                 overflow,
  input  logic [CH_W-1:0]      cnt_sel,
  output logic [CNT_W-1:0]     cnt_out,
  change_event_monitor_if.master rec
);

  logic [WIDTH-1:0] prev_q [NCH];
  logic             primed_q;
  logic [NCH-1:0]   evt_pulse_q;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [WIDTH-1:0] pend_val_q [NCH];
  logic [TS_W-1:0]  pend_ts_q [NCH];
  logic [TS_W-1:0]  ts_q;
  logic             overflow_q;

  logic [CH_W-1:0]  mem_ch  [DEPTH];
  logic [WIDTH-1:0] mem_val [DEPTH];
  logic [TS_W-1:0]  mem_ts  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  logic [NCH-1:0]   hit, load, drop, drain_oh, drain_done;
  logic [CH_W-1:0]  drain_ch;
  logic             push, pop, head_valid;

  always_comb begin
    hit  = '0;
    load = '0;
    drop = '0;
    for (int c = 0; c < NCH; c++) begin
      logic [WIDTH-1:0] cur;
      logic             cond;
      cur = din[c*WIDTH +: WIDTH];
      if (MODE == 1)      cond = cur > prev_q[c];
      else if (MODE == 2) cond = cur < prev_q[c];
      else                cond = cur != prev_q[c];
      hit[c]  = sample_en & (primed_q ? cond : (FIRST_CHANGE != 0));
      load[c] = hit[c] & (~pend_q[c] | drain_done[c]);
      drop[c] = hit[c] & pend_q[c] & ~drain_done[c];
    end
  end

  // Lowest-index pending slot wins the single push port.
  always_comb begin
    drain_oh = '0;
    drain_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        drain_oh = NCH'(1) << i;
        drain_ch = CH_W'(i);
      end
    end
  end

  assign head_valid = (count_q != '0);
  assign pop        = head_valid & rec.rec_ready;
  assign push       = (|pend_q) & ((count_q < (PTR_W+1)'(DEPTH)) | pop);
  assign drain_done = push ? drain_oh : '0;
  assign pend_d     = (pend_q & ~drain_done) | load;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        prev_q[c]     <= '0;
        pend_val_q[c] <= '0;
        pend_ts_q[c]  <= '0;
      end
      primed_q    <= 1'b0;
      evt_pulse_q <= '0;
      pend_q      <= '0;
      ts_q        <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      ts_q        <= ts_q + 1'b1;
      evt_pulse_q <= hit;
      pend_q      <= pend_d;
      count_q     <= count_d;
      if (sample_en) begin
        primed_q <= 1'b1;
        for (int c = 0; c < NCH; c++) prev_q[c] <= din[c*WIDTH +: WIDTH];
      end
      for (int c = 0; c < NCH; c++) begin
        if (load[c]) begin
          pend_val_q[c] <= din[c*WIDTH +: WIDTH];
          pend_ts_q[c]  <= ts_q;
        end
      end
      if (clear)        overflow_q <= 1'b0;
      else if (|drop)   overflow_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_ch[wr_ptr_q]  <= drain_ch;
      mem_val[wr_ptr_q] <= pend_val_q[drain_ch];
      mem_ts[wr_ptr_q]  <= pend_ts_q[drain_ch];
    end
  end

  // Head fields are masked so stale storage never shows while the FIFO is empty.
  assign rec.rec_valid = head_valid;
  assign rec.rec_ch    = head_valid ? mem_ch[rd_ptr_q]  : '0;
  assign rec.rec_val   = head_valid ? mem_val[rd_ptr_q] : '0;
  assign rec.rec_ts    = head_valid ? mem_ts[rd_ptr_q]  : '0;

  assign evt_pulse  = evt_pulse_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

`ifdef CHANGE_EVENT_MONITOR_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_out_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
      cnt_out_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (clear)                         cnt_q[c] <= '0;
        else if (hit[c] && cnt_q[c] != '1) cnt_q[c] <= cnt_q[c] + 1'b1;
      end
      cnt_out_q <= (int'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : '0;
    end
  end

  assign cnt_out = cnt_out_q;
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out        = '0;
`endif

endmodule
